// File: rtl/can_bus_access_sequencer.sv
// -----------------------------------------------------------------------------
// can_bus_access_sequencer
//
// Purpose:
//   Converts a decoded 68k access to one of two byte-wide, multiplexed-AD CAN
//   controllers into an ALE / CS / RD / WR cycle on a single shared AD bus.
//   It returns read data and Dtack_L to the 68k, and leaves an idle recovery
//   gap after every access. Every output comes straight from a flop, and each
//   flop is loaded with the value the next state calls for. Outputs therefore
//   change on the same edge as the state.
//
// Ports:
//   Clk            system clock
//   Reset_H        synchronous active-high reset
//   AS_L           68k address strobe (active low)
//   WE_L           68k write enable: 0 = write, 1 = read
//   CAN_Enable0_H  decoder select for CAN0 (wins when both are high)
//   CAN_Enable1_H  decoder select for CAN1
//   Address[7:0]   CAN register number
//   DataIn[7:0]    68k write data
//   DataOut[7:0]   read data returned to the 68k
//   Dtack_L        68k data acknowledge (active low)
//   CAN_AD_Out     value driven on the shared AD bus
//   CAN_AD_OE_H    AD output enable; 0 = tri-state
//   CAN_AD_In      AD bus readback
//   CAN_ALE_H      address latch enable
//   CAN_RD_L       read strobe
//   CAN_WR_L       write strobe
//   CAN_CS0_L      CAN0 chip select
//   CAN_CS1_L      CAN1 chip select
// -----------------------------------------------------------------------------
module can_bus_access_sequencer #(
   parameter int unsigned ALE_CYCLES      = 2,
   parameter int unsigned SETUP_CYCLES    = 1,
   parameter int unsigned STROBE_CYCLES   = 4,
   parameter int unsigned RECOVERY_CYCLES = 3
) (
   input  logic       Clk,
   input  logic       Reset_H,
   input  logic       AS_L,
   input  logic       WE_L,
   input  logic       CAN_Enable0_H,
   input  logic       CAN_Enable1_H,
   input  logic [7:0] Address,
   input  logic [7:0] DataIn,
   output logic [7:0] DataOut,
   output logic       Dtack_L,
   output logic [7:0] CAN_AD_Out,
   output logic       CAN_AD_OE_H,
   input  logic [7:0] CAN_AD_In,
   output logic       CAN_ALE_H,
   output logic       CAN_RD_L,
   output logic       CAN_WR_L,
   output logic       CAN_CS0_L,
   output logic       CAN_CS1_L
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ALAT,
      S_STRB,
      S_ACK,
      S_RECOV
   } state_t;

   // Each timed state loads the shared down-counter with N-1 when it is
   // entered. The state leaves on the edge that finds the counter at zero.
   localparam logic [3:0] ALE_LOAD   = 4'(ALE_CYCLES - 1);
   localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] STRB_LOAD  = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] RECOV_LOAD = 4'(RECOVERY_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   // Request fields latched at the start edge
   logic       to_can1_q, to_can1_d;
   logic       is_read_q, is_read_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       abort_q, abort_d;   // AS_L seen high before ACK

   // Registered outputs
   logic [7:0] data_out_q, data_out_d;
   logic       dtack_q, dtack_d;
   logic [7:0] ad_out_q, ad_out_d;
   logic       ad_oe_q, ad_oe_d;
   logic       ale_q, ale_d;
   logic       rd_l_q, rd_l_d;
   logic       wr_l_q, wr_l_d;
   logic       cs0_q, cs0_d;
   logic       cs1_q, cs1_d;

   logic       start;
   logic       drive_addr;
   logic       strobe;

   assign start = !AS_L && (CAN_Enable0_H || CAN_Enable1_H);

   // Next-state and request-latch logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      to_can1_d = to_can1_q;
      is_read_d = is_read_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      abort_d   = abort_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_ADDR;
               cnt_d     = ALE_LOAD;
               to_can1_d = !CAN_Enable0_H;
               is_read_d = WE_L;
               addr_d    = Address;
               wdata_d   = DataIn;
               abort_d   = 1'b0;
            end
         end
         S_ADDR: begin
            if (AS_L) abort_d = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = S_ALAT;
               cnt_d   = SETUP_LOAD;
            end
         end
         S_ALAT: begin
            if (AS_L) abort_d = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = S_STRB;
               cnt_d   = STRB_LOAD;
            end
         end
         S_STRB: begin
            // An abort never shortens the strobe. It only suppresses Dtack.
            if (AS_L) abort_d = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = S_ACK;
               cnt_d   = 4'd0;
            end
         end
         S_ACK: begin
            if (AS_L || abort_q) begin
               state_d = S_RECOV;
               cnt_d   = RECOV_LOAD;
            end
         end
         S_RECOV: begin
            if (cnt_q == 4'd0) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Output values for the state being entered
   always_comb begin
      drive_addr = (state_d == S_ADDR) || (state_d == S_ALAT);
      strobe     = (state_d == S_STRB);

      ale_d    = (state_d == S_ADDR);
      ad_oe_d  = drive_addr || (strobe && !is_read_d);
      ad_out_d = 8'h00;
      if (drive_addr)
         ad_out_d = addr_d;
      else if (strobe && !is_read_d)
         ad_out_d = wdata_d;

      cs0_d  = !(strobe && !to_can1_d);
      cs1_d  = !(strobe && to_can1_d);
      rd_l_d = !(strobe && is_read_d);
      wr_l_d = !(strobe && !is_read_d);

      // Acknowledge only for a cycle that was never aborted, and only while
      // the 68k still holds AS_L low.
      dtack_d = !((state_d == S_ACK) && !AS_L && !abort_d);

      // Capture read data on the last strobe edge, while RD_L is still low
      data_out_d = data_out_q;
      if ((state_q == S_STRB) && (cnt_q == 4'd0) && is_read_q)
         data_out_d = CAN_AD_In;
   end

   always_ff @(posedge Clk) begin
      if (Reset_H) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         to_can1_q  <= 1'b0;
         is_read_q  <= 1'b0;
         addr_q     <= 8'h00;
         wdata_q    <= 8'h00;
         abort_q    <= 1'b0;
         data_out_q <= 8'h00;
         dtack_q    <= 1'b1;
         ad_out_q   <= 8'h00;
         ad_oe_q    <= 1'b0;
         ale_q      <= 1'b0;
         rd_l_q     <= 1'b1;
         wr_l_q     <= 1'b1;
         cs0_q      <= 1'b1;
         cs1_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         to_can1_q  <= to_can1_d;
         is_read_q  <= is_read_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         abort_q    <= abort_d;
         data_out_q <= data_out_d;
         dtack_q    <= dtack_d;
         ad_out_q   <= ad_out_d;
         ad_oe_q    <= ad_oe_d;
         ale_q      <= ale_d;
         rd_l_q     <= rd_l_d;
         wr_l_q     <= wr_l_d;
         cs0_q      <= cs0_d;
         cs1_q      <= cs1_d;
      end
   end

   assign DataOut     = data_out_q;
   assign Dtack_L     = dtack_q;
   assign CAN_AD_Out  = ad_out_q;
   assign CAN_AD_OE_H = ad_oe_q;
   assign CAN_ALE_H   = ale_q;
   assign CAN_RD_L    = rd_l_q;
   assign CAN_WR_L    = wr_l_q;
   assign CAN_CS0_L   = cs0_q;
   assign CAN_CS1_L   = cs1_q;

endmodule
